// File: rtl/dp_mem_responder.sv
// dp_mem_responder
// ----------------
// Memory-side responder between the datapath request interface and one
// shared single-ported RAM. It serves instruction fetches and data
// loads/stores one at a time. Data requests win over fetches. ihit and dhit
// are returned as one-cycle completion pulses that advance the pipeline.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   halt               blocks acceptance of new accesses while high
//   imemREN/imemaddr   instruction fetch request
//   dmemREN/dmemWEN    data load / store request
//   dmemaddr/dmemstore data address and store data
//   ihit/dhit          one-cycle completion pulses
//   imemload/dmemload  last fetched instruction / last loaded data
//   ramREN/ramWEN      RAM read / write strobes (registered)
//   ramaddr/ramstore   RAM address / write data (registered)
//   ramload/ramready   RAM read data and completion
//   ramerr             RAM failed-access indication
//   err                sticky error flag (cleared only by reset)

module dp_mem_responder #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 TIMEOUT  = 15,
  parameter logic [DATA_W-1:0]  ERR_WORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerr,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The counter still reads TIMEOUT-1 during the TIMEOUT'th ACC cycle,
  // so the forced completion happens at the end of exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IW   = 2'd1,
    REQ_DR   = 2'd2,
    REQ_DW   = 2'd3
  } reqType_t;

  state_t             r_state;
  reqType_t           r_type;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_store;
  logic [CNT_W-1:0]   r_count;
  logic               r_ramREN;
  logic               r_ramWEN;
  logic [DATA_W-1:0]  r_imemload;
  logic [DATA_W-1:0]  r_dmemload;
  logic               r_err;

  logic               w_anyReq;
  logic               w_timeout;
  logic               w_fail;
  logic               w_accEnd;
  logic [DATA_W-1:0]  w_loadVal;

  assign w_anyReq  = dmemWEN | dmemREN | imemREN;
  // ramready in the last allowed cycle still counts as a normal completion.
  assign w_timeout = !ramready && (r_count == LAST_CNT);
  // An error wins even when ramready arrives in the same cycle.
  assign w_fail    = ramerr | w_timeout;
  assign w_accEnd  = ramerr | ramready | w_timeout;
  assign w_loadVal = w_fail ? ERR_WORD : ramload;

  // Main FSM: accepts one request in IDLE, holds the RAM strobes for the
  // whole ACC phase, and spends one DONE cycle signalling completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_type     <= REQ_NONE;
      r_addr     <= '0;
      r_store    <= '0;
      r_count    <= '0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_imemload <= '0;
      r_dmemload <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!halt && w_anyReq) begin
            r_state <= ACC;
            r_store <= dmemstore;
            if (dmemWEN) begin
              // A simultaneous read+write is malformed: do the store, flag it.
              r_type   <= REQ_DW;
              r_addr   <= dmemaddr;
              r_ramWEN <= 1'b1;
              if (dmemREN) begin
                r_err <= 1'b1;
              end
            end else if (dmemREN) begin
              r_type   <= REQ_DR;
              r_addr   <= dmemaddr;
              r_ramREN <= 1'b1;
            end else begin
              r_type   <= REQ_IW;
              r_addr   <= imemaddr;
              r_ramREN <= 1'b1;
            end
          end
        end
        ACC: begin
          r_count <= r_count + 1'b1;
          if (w_accEnd) begin
            r_state  <= DONE;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            if (w_fail) begin
              r_err <= 1'b1;
            end
            if (r_type == REQ_IW) begin
              r_imemload <= w_loadVal;
            end else if (r_type == REQ_DR) begin
              r_dmemload <= w_loadVal;
            end
          end
        end
        DONE: begin
          r_count <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Hits are qualified by the live request so a request withdrawn during
  // the access (e.g. a pipeline flush) gets no completion pulse.
  assign ihit = (r_state == DONE) && (r_type == REQ_IW) && imemREN;
  assign dhit = (r_state == DONE) &&
                (((r_type == REQ_DR) && dmemREN) || ((r_type == REQ_DW) && dmemWEN));

  assign imemload = r_imemload;
  assign dmemload = r_dmemload;
  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign err      = r_err;

endmodule

// File: tb/tb_dp_mem_responder.sv
// tb_dp_mem_responder
// -------------------
// Self-checking bench for dp_mem_responder. Each access is described at the
// transaction level (which requests are raised, when the RAM answers, whether
// it reports an error). A small reference model derives the selected request,
// the expected RAM strobes, the completion cycle, the hit and the load values.

module tb_dp_mem_responder;

  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  logic        CLK;
  logic        nRST;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        ramerr;
  logic        err;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state: the values the datapath should currently see.
  logic [31:0] expImem = '0;
  logic [31:0] expDmem = '0;
  logic        expErr  = 1'b0;

  dp_mem_responder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT),
    .ERR_WORD(ERR_WORD)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .halt     (halt),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .ihit     (ihit),
    .dhit     (dhit),
    .imemload (imemload),
    .dmemload (dmemload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramready (ramready),
    .ramerr   (ramerr),
    .err      (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic dropInputs();
    imemREN  = 1'b0;
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    halt     = 1'b0;
    ramready = 1'b0;
    ramerr   = 1'b0;
  endtask

  // One access. Called #1 after a clock edge with the DUT idle.
  // eventAt: ACC cycle (1-based) in which the RAM answers; > TIMEOUT means never.
  task automatic applyStimulus(input bit iR, input bit dR, input bit dW,
                               input logic [31:0] iA, input logic [31:0] dA,
                               input logic [31:0] sD, input logic [31:0] rdData,
                               input int eventAt, input bit errInj,
                               input bit withdraw, input bit haltAcc);
    bit          isI;
    bit          isStore;
    bit          fail;
    int          nAcc;
    logic [31:0] expAddr;
    imemREN   = iR;
    dmemREN   = dR;
    dmemWEN   = dW;
    imemaddr  = iA;
    dmemaddr  = dA;
    dmemstore = sD;
    halt      = 1'b0;
    ramready  = 1'b0;
    ramerr    = 1'b0;
    if (!(iR || dR || dW)) begin
      @(posedge CLK); #1;
      checkOutput("idle_ramREN", {31'b0, ramREN}, 32'd0);
      checkOutput("idle_ramWEN", {31'b0, ramWEN}, 32'd0);
      return;
    end
    // Model: store beats load beats fetch; the malformed read+write is an error.
    isStore = dW;
    isI     = !dW && !dR;
    expAddr = (dW || dR) ? dA : iA;
    if (dW && dR) expErr = 1'b1;
    nAcc = (eventAt <= TIMEOUT) ? eventAt : TIMEOUT;
    fail = (eventAt > TIMEOUT) || errInj;
    for (int k = 1; k <= nAcc; k++) begin
      @(posedge CLK); #1;
      checkOutput("acc_ramREN", {31'b0, ramREN}, {31'b0, !isStore});
      checkOutput("acc_ramWEN", {31'b0, ramWEN}, {31'b0, isStore});
      checkOutput("acc_hits", {30'b0, ihit, dhit}, 32'd0);
      if (k == 1) begin
        checkOutput("acc_ramaddr", ramaddr, expAddr);
        if (isStore) checkOutput("acc_ramstore", ramstore, sD);
      end
      ramload  = (k == eventAt) ? rdData : $urandom;
      ramerr   = (k == eventAt) && errInj;
      ramready = (k == eventAt) && (!errInj || $urandom_range(0, 1) == 1);
      if (withdraw && k == 1) begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
      if (haltAcc) halt = 1'b1;
    end
    // Completion: loads update their own register; stores touch neither.
    if (fail) expErr = 1'b1;
    if (isI) expImem = fail ? ERR_WORD : rdData;
    else if (!isStore) expDmem = fail ? ERR_WORD : rdData;
    @(posedge CLK); #1;
    checkOutput("done_ihit", {31'b0, ihit}, {31'b0, isI && !withdraw});
    checkOutput("done_dhit", {31'b0, dhit}, {31'b0, !isI && !withdraw});
    checkOutput("done_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    checkOutput("imemload", imemload, expImem);
    checkOutput("dmemload", dmemload, expDmem);
    checkOutput("err", {31'b0, err}, {31'b0, expErr});
    dropInputs();
    @(posedge CLK); #1;
    checkOutput("post_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    checkOutput("post_hits", {30'b0, ihit, dhit}, 32'd0);
  endtask

  // halt in IDLE must block acceptance entirely.
  task automatic haltCheck();
    halt     = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checkOutput("halt_ramREN", {31'b0, ramREN}, 32'd0);
      checkOutput("halt_ihit", {31'b0, ihit}, 32'd0);
    end
    dropInputs();
  endtask

  // Reset in the middle of an access drops everything asynchronously.
  task automatic resetMidAccess();
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    @(posedge CLK); #1;
    checkOutput("rst_pre_ramREN", {31'b0, ramREN}, 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    checkOutput("rst_hits", {30'b0, ihit, dhit}, 32'd0);
    checkOutput("rst_imemload", imemload, 32'd0);
    checkOutput("rst_dmemload", dmemload, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    expImem = '0;
    expDmem = '0;
    expErr  = 1'b0;
    dropInputs();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST      = 1'b0;
    imemaddr  = '0;
    dmemaddr  = '0;
    dmemstore = '0;
    ramload   = '0;
    dropInputs();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", {28'b0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    checkOutput("reset_loads", imemload | dmemload, 32'd0);
    checkOutput("reset_err", {31'b0, err}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Directed cases.
    applyStimulus(1, 0, 0, 32'h4, 32'h0, 32'h0, 32'h2001_0005, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h8, 32'h100, 32'h0, 32'h1234_5678, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h8, 32'h0, 32'h0, 32'h0A0B_0C0D, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0, 32'h200, 32'hDEAD_BEEF, 32'h5555_AAAA, 2, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 32'h0, 32'h7777_0001, 3, 0, 1, 0);
    applyStimulus(0, 1, 0, 32'h0, 32'h300, 32'h0, 32'h3333_3333, 4, 0, 0, 1);
    haltCheck();
    applyStimulus(0, 1, 0, 32'h0, 32'h400, 32'h0, 32'h0, 99, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, 32'h404, 32'h0, 32'h9999_9999, TIMEOUT, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h14, 32'h0, 32'h0, 32'h6666_6666, 2, 1, 0, 0);
    resetMidAccess();
    applyStimulus(0, 1, 1, 32'h0, 32'h500, 32'hCAFE_F00D, 32'h0, 1, 0, 0, 0);
    resetMidAccess();

    // Randomized accesses against the model.
    for (int n = 0; n < 60; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Memory-side responder for the datapath-to-cache request interface. It services the datapath's instruction-fetch and data load/store requests over one shared single-ported RAM.
- It generates the ihit/dhit completion handshakes that stall or advance the pipeline, and returns imemload/dmemload.
- Data requests have priority over instruction fetches. A per-access timeout guards against a hung RAM.

Parameters:
- ADDR_W, 32, address width of imemaddr/dmemaddr/ramaddr
- DATA_W, 32, data width of all load/store buses
- TIMEOUT, 15, maximum ACC-state cycles waiting for ramready before forced completion
- ERR_WORD, 32'hBAD1BAD1, load value returned on timeout or RAM error

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- halt  in  1  datapath halted; no new accesses accepted
- imemREN  in  1  instruction fetch request
- imemaddr  in  ADDR_W  fetch address
- dmemREN  in  1  data load request
- dmemWEN  in  1  data store request
- dmemaddr  in  ADDR_W  data address
- dmemstore  in  DATA_W  store data
- ihit  out  1  fetch complete (1-cycle pulse)
- dhit  out  1  data access complete (1-cycle pulse)
- imemload  out  DATA_W  fetched instruction
- dmemload  out  DATA_W  loaded data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid with ramready
- ramready  in  1  RAM access complete this cycle
- ramerr  in  1  RAM reports failed access, sampled with/without ramready
- err  out  1  sticky error flag

Behaviour:
- Reset (nRST=0, async, clock CLK): state IDLE; all outputs 0; timeout counter 0; latched request registers 0; err 0. A reset mid-access abandons the access immediately and drops ramREN/ramWEN the same instant.
- FSM has three states: IDLE, ACC, DONE.
- IDLE → ACC when halt=0 and any request is present:
  - Selection priority: dmemWEN > dmemREN > imemREN.
  - Latch type (IW / DR / DW), address and dmemstore into internal registers.
  - If dmemREN and dmemWEN are both 1: perform the store and set err.
  - With halt=1 or no request, stay in IDLE.
- ACC:
  - Drive ramaddr/ramstore from the latched registers, plus ramREN (DR, IW) or ramWEN (DW).
  - RAM strobes are registered outputs, stable for the whole of ACC and 0 outside ACC.
  - The counter increments each ACC cycle.
- ACC → DONE on the first of:
  - ramready=1 with ramerr=0: capture ramload into imemload (IW) or dmemload (DR); a store updates neither.
  - ramerr=1: load target gets ERR_WORD; set err.
  - Counter reaches TIMEOUT with no ramready: load target gets ERR_WORD; set err.
- DONE:
  - Assert exactly one of ihit/dhit for one cycle, then return to IDLE. The counter clears.
  - The hit is suppressed if the matching request is no longer asserted in DONE (request withdrawn, e.g. flush). The RAM access, including any store, still completes.
- Latency: request visible in IDLE at cycle 0 → earliest hit in cycle 2, when ramready arrives in cycle 1. Worst case is TIMEOUT+1 cycles.
- The DONE→IDLE cycle gives the datapath one edge to present its next request. Back-to-back accesses take 3+ cycles each.
- imemload/dmemload hold their last value until the next completion of their own type.
- halt does not abort an ACC in progress; it only blocks new acceptance. ihit/dhit stay 0 whenever halt=1 and the FSM is in IDLE.
- Simultaneous events: ramready and ramerr in the same cycle → treated as an error. err is sticky until reset.

Test Plan:
- Fetch only: imemREN=1, imemaddr=0x0000_0004; RAM returns ramload=0x2001_0005 with ramready one cycle after ramREN → ramaddr=0x4 and ramREN=1 for 1 cycle; ihit pulses in cycle 2; imemload=0x2001_0005; dhit=0.
- Data priority: imemREN=1 @0x8 and dmemREN=1 @0x100 together, RAM 0-wait → first access has ramaddr=0x100 with dhit, dmemload=ramload. The next access has ramaddr=0x8 with ihit.
- Store: dmemWEN=1, dmemaddr=0x200, dmemstore=0xDEAD_BEEF → ramWEN=1, ramstore=0xDEADBEEF, ramaddr=0x200; dhit pulses; dmemload unchanged.
- Timeout: dmemREN=1, ramready held 0 → after 15 ACC cycles, dhit pulses and dmemload=0xBAD1BAD1; err=1 and stays 1.
- Withdraw/halt:
  - Drop imemREN during ACC → access finishes and no ihit.
  - Assert halt in IDLE with imemREN=1 → no ramREN, ihit=0.
  - Pull nRST low mid-ACC → all outputs 0 immediately.
